// File: rtl/multi_hit_stretch_if.sv
// multi_hit_stretch_if: hit/clear inputs and stretched-hit outputs of the stretcher.
// master = front end + readout side, slave = multi_hit_stretch.
interface multi_hit_stretch_if #(
    parameter int CH    = 8,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       hit;
    logic [CH-1:0]       clr;
    logic                cnt_clr;
    logic [CH-1:0]       stretch_hit;
    logic [CH-1:0]       stretch_rise;
    logic [CH*CNT_W-1:0] miss_cnt;
    logic                busy;
    logic [CH-1:0]       timeout;

    modport master (
        output hit, clr, cnt_clr,
        input  stretch_hit, stretch_rise, miss_cnt, busy, timeout
    );

    modport slave (
        input  hit, clr, cnt_clr,
        output stretch_hit, stretch_rise, miss_cnt, busy, timeout
    );
endinterface

// File: rtl/multi_hit_stretch.sv
// multi_hit_stretch: N-channel hit stretcher with min width, dead time, miss counters.
// Ports: clk, rst_n (async low), bus (slave): hit/clr/cnt_clr in;
//   stretch_hit/stretch_rise/miss_cnt/busy/timeout out. Macro STRETCH_TIMEOUT_EN
//   enables auto-release of HOLD after TIMEOUT cycles.
module multi_hit_stretch #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 255
) (
    input logic                clk,
    input logic                rst_n,
    multi_hit_stretch_if.slave bus
);
    // Width counter saturates at the larger of the two limits it is compared to.
    localparam int TO_EFF = (TIMEOUT < MIN_WIDTH) ? MIN_WIDTH : TIMEOUT;
    localparam int WW     = $clog2(TO_EFF + 1);
    localparam int DW     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int DLAST  = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

    localparam logic [WW-1:0]    MIN_W   = WW'(MIN_WIDTH);
    localparam logic [WW-1:0]    W_MAX   = WW'(TO_EFF);
    localparam logic [DW-1:0]    D_LAST  = DW'(DLAST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DEAD
    } state_t;

    logic [CH-1:0]    sync_q [SYNC_STAGES];
    logic [CH-1:0]    sync_dly;
    logic [CH-1:0]    rise_q;

    state_t           state_q [CH];
    state_t           state_d [CH];
    logic [WW-1:0]    width_q [CH];
    logic [WW-1:0]    width_d [CH];
    logic [DW-1:0]    dcnt_q  [CH];
    logic [DW-1:0]    dcnt_d  [CH];
    logic [CNT_W-1:0] cnt_q   [CH];
    logic [CNT_W-1:0] cnt_d   [CH];

    logic [CH-1:0]    pend_q, pend_d;
    logic [CH-1:0]    sh_q, sh_d;
    logic [CH-1:0]    sr_q, sr_d;
    logic [CH-1:0]    miss;
    logic [CH-1:0]    rel;
`ifdef STRETCH_TIMEOUT_EN
    logic [CH-1:0]    to_q, to_d;
`endif

    // Synchroniser, then a delayed copy; the edge itself is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_dly <= '0;
            rise_q   <= '0;
        end else begin
            sync_q[0] <= bus.hit;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_dly <= sync_q[SYNC_STAGES-1];
            rise_q   <= sync_q[SYNC_STAGES-1] & ~sync_dly;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                width_q[i] <= '0;
                dcnt_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
            pend_q <= '0;
            sh_q   <= '0;
            sr_q   <= '0;
`ifdef STRETCH_TIMEOUT_EN
            to_q   <= '0;
`endif
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                width_q[i] <= width_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q <= pend_d;
            sh_q   <= sh_d;
            sr_q   <= sr_d;
`ifdef STRETCH_TIMEOUT_EN
            to_q   <= to_d;
`endif
        end
    end

    always_comb begin
        pend_d = pend_q;
        sh_d   = '0;
        sr_d   = '0;
        miss   = '0;
        rel    = '0;
`ifdef STRETCH_TIMEOUT_EN
        to_d   = '0;
`endif
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            width_d[i] = width_q[i];
            dcnt_d[i]  = dcnt_q[i];
            cnt_d[i]   = cnt_q[i];

            unique case (state_q[i])
                IDLE: begin
                    if (rise_q[i]) begin
                        state_d[i] = HOLD;
                        width_d[i] = WW'(1);
                        pend_d[i]  = 1'b0;
                        sr_d[i]    = 1'b1;
                    end
                end
                HOLD: begin
                    miss[i] = rise_q[i];
                    if (width_q[i] != W_MAX) width_d[i] = width_q[i] + 1'b1;
                    // A clr seen before MIN_WIDTH is remembered until release.
                    if ((pend_q[i] | bus.clr[i]) && (width_q[i] >= MIN_W)) begin
                        rel[i] = 1'b1;
                    end else begin
                        pend_d[i] = pend_q[i] | bus.clr[i];
                    end
`ifdef STRETCH_TIMEOUT_EN
                    if (!rel[i] && (width_q[i] >= W_MAX)) begin
                        rel[i]  = 1'b1;
                        to_d[i] = 1'b1;
                    end
`endif
                    if (rel[i]) begin
                        pend_d[i]  = 1'b0;
                        dcnt_d[i]  = '0;
                        state_d[i] = (DEAD_CYCLES == 0) ? IDLE : DEAD;
                    end
                end
                DEAD: begin
                    miss[i] = rise_q[i];
                    if (dcnt_q[i] == D_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            sh_d[i] = (state_d[i] == HOLD);

            if (bus.cnt_clr) begin
                cnt_d[i] = '0;
            end else if (miss[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cnt
        assign bus.miss_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign bus.stretch_hit  = sh_q;
    assign bus.stretch_rise = sr_q;
    assign bus.busy         = |sh_q;
`ifdef STRETCH_TIMEOUT_EN
    assign bus.timeout      = to_q;
`else
    assign bus.timeout      = '0;
`endif
endmodule
